// File: rtl/bp_pma_sched.sv
// bp_pma_sched: round-robin arbiter of I-side and D-side requests onto one
// PMA classifier (cached/uncached), result held in a one-entry response reg.
// Ports: clk_i, reset_n_i (async, active-low); req_v_i/req_ptag_i/req_yumi_o
// (two requesters); flush_i; resp_v_o/resp_id_o/resp_ptag_o/resp_uncached_o
// with resp_yumi_i; uc_count_o only when BP_PMA_SCHED_STATS_EN is defined.
module bp_pma_sched #(
    parameter int ptag_width_p = 28,
    parameter logic [ptag_width_p-1:0] dram_base_ptag_p = 28'h0080000,
    parameter int io_did_width_p = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [1:0]                req_v_i,
    input  logic [2*ptag_width_p-1:0] req_ptag_i,
    output logic [1:0]                req_yumi_o,
    input  logic                      flush_i,
    output logic                      resp_v_o,
    output logic                      resp_id_o,
    output logic [ptag_width_p-1:0]   resp_ptag_o,
    output logic                      resp_uncached_o,
    input  logic                      resp_yumi_i
`ifdef BP_PMA_SCHED_STATS_EN
    ,
    output logic [15:0]               uc_count_o
`endif
);

    localparam logic e_empty = 1'b0;
    localparam logic e_full  = 1'b1;

    logic                    state_r;
    logic                    rr_r;
    logic                    id_r;
    logic [ptag_width_p-1:0] ptag_r;
    logic                    unc_r;

    logic                    can_accept;
    logic                    pref_v;
    logic                    alt_v;
    logic                    gnt_v;
    logic                    gnt_id;
    logic [ptag_width_p-1:0] gnt_ptag;
    logic                    is_local;
    logic                    is_io;
    logic                    gnt_unc;
    logic                    consume;

    // A full register can still accept when it is drained this same cycle.
    assign can_accept = ~flush_i & ((state_r == e_empty) | resp_yumi_i);

    assign pref_v = req_v_i[rr_r];
    assign alt_v  = req_v_i[~rr_r];
    assign gnt_v  = can_accept & (pref_v | alt_v);
    assign gnt_id = pref_v ? rr_r : ~rr_r;

    always_comb begin
        req_yumi_o = 2'b00;
        if (gnt_v) begin
            req_yumi_o[gnt_id] = 1'b1;
        end
    end

    assign gnt_ptag = gnt_id ? req_ptag_i[ptag_width_p +: ptag_width_p]
                             : req_ptag_i[0 +: ptag_width_p];

    assign is_local = gnt_ptag < dram_base_ptag_p;
    assign is_io    = |gnt_ptag[ptag_width_p-1 -: io_did_width_p+1];
    assign gnt_unc  = is_local | is_io;

    assign consume = (state_r == e_full) & resp_yumi_i & ~flush_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_empty;
            rr_r    <= 1'b0;
            id_r    <= 1'b0;
            ptag_r  <= '0;
            unc_r   <= 1'b0;
        end else if (flush_i) begin
            state_r <= e_empty;
        end else if (gnt_v) begin
            state_r <= e_full;
            rr_r    <= ~gnt_id;
            id_r    <= gnt_id;
            ptag_r  <= gnt_ptag;
            unc_r   <= gnt_unc;
        end else if (consume) begin
            state_r <= e_empty;
        end
    end

    assign resp_v_o        = (state_r == e_full);
    assign resp_id_o       = id_r;
    assign resp_ptag_o     = ptag_r;
    assign resp_uncached_o = unc_r;

`ifdef BP_PMA_SCHED_STATS_EN
    logic [15:0] uc_count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            uc_count_r <= '0;
        end else if (consume & unc_r & (uc_count_r != 16'hFFFF)) begin
            uc_count_r <= uc_count_r + 16'd1;
        end
    end

    assign uc_count_o = uc_count_r;
`endif

endmodule

// File: tb/tb_bp_pma_sched.sv
// tb_bp_pma_sched: table-driven vectors with a response scoreboard
// for bp_pma_sched, plus reset and stats sequences.
module tb_bp_pma_sched;

    localparam logic [27:0] P_C  = 28'h0080000;
    localparam logic [27:0] P_L  = 28'h007FFFF;
    localparam logic [27:0] P_IO = 28'h1000000;
    localparam logic [27:0] P_X  = 28'h0123456;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [1:0]  req_v_i = 2'b00;
    logic [55:0] req_ptag_i = '0;
    logic [1:0]  req_yumi_o;
    logic        flush_i = 1'b0;
    logic        resp_v_o;
    logic        resp_id_o;
    logic [27:0] resp_ptag_o;
    logic        resp_uncached_o;
    logic        resp_yumi_i = 1'b0;
`ifdef BP_PMA_SCHED_STATS_EN
    logic [15:0] uc_count_o;
`endif

    bp_pma_sched dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .req_v_i         (req_v_i),
        .req_ptag_i      (req_ptag_i),
        .req_yumi_o      (req_yumi_o),
        .flush_i         (flush_i),
        .resp_v_o        (resp_v_o),
        .resp_id_o       (resp_id_o),
        .resp_ptag_o     (resp_ptag_o),
        .resp_uncached_o (resp_uncached_o),
        .resp_yumi_i     (resp_yumi_i)
`ifdef BP_PMA_SCHED_STATS_EN
        ,
        .uc_count_o      (uc_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  v;
        logic [27:0] p0;
        logic [27:0] p1;
        logic        yumi;
        logic        flush;
        logic [1:0]  exp_yumi;
    } vec_t;

    typedef struct {
        logic        id;
        logic [27:0] ptag;
        logic        unc;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(logic [1:0] v, logic [27:0] p0,
                                logic [27:0] p1, logic y, logic f,
                                logic [1:0] e);
        vec_t t;
        t.v = v;
        t.p0 = p0;
        t.p1 = p1;
        t.yumi = y;
        t.flush = f;
        t.exp_yumi = e;
        return t;
    endfunction

    function automatic logic uc(logic [27:0] p);
        return (p < 28'h0080000) || (p[27:24] != 4'h0);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t t);
        rsp_t r;
        @(negedge clk_i);
        req_v_i = t.v;
        req_ptag_i = {t.p1, t.p0};
        resp_yumi_i = t.yumi;
        flush_i = t.flush;
        #1;
        chk("req_yumi", 32'(req_yumi_o), 32'(t.exp_yumi));
        chk("resp_v", 32'(resp_v_o), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("resp_id", 32'(resp_id_o), 32'(sb[0].id));
            chk("resp_ptag", 32'(resp_ptag_o), 32'(sb[0].ptag));
            chk("resp_unc", 32'(resp_uncached_o), 32'(sb[0].unc));
        end
        if (t.flush) begin
            sb.delete();
        end else begin
            if (t.yumi && sb.size() != 0) void'(sb.pop_front());
            if (t.exp_yumi != 2'b00) begin
                r.id = t.exp_yumi[1];
                r.ptag = t.exp_yumi[1] ? t.p1 : t.p0;
                r.unc = uc(r.ptag);
                sb.push_back(r);
            end
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) step(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        #12;
        chk("rst_resp_v", 32'(resp_v_o), 32'd0);
        chk("rst_resp_ptag", 32'(resp_ptag_o), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // single requests and classification boundaries
        vecs.push_back(mk(2'b01, P_C,  P_X, 1'b0, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, P_L,  P_X, 1'b1, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, P_IO, P_X, 1'b1, 1'b0, 2'b01));
        vecs.push_back(mk(2'b00, P_X,  P_X, 1'b1, 1'b0, 2'b00));
        vecs.push_back(mk(2'b10, P_C,  P_L, 1'b0, 1'b0, 2'b10));
        vecs.push_back(mk(2'b00, P_X,  P_X, 1'b1, 1'b0, 2'b00));
        // contention
        vecs.push_back(mk(2'b11, P_C,  P_IO, 1'b0, 1'b0, 2'b01));
        vecs.push_back(mk(2'b11, P_L,  P_X,  1'b1, 1'b0, 2'b10));
        vecs.push_back(mk(2'b11, P_IO, P_C,  1'b1, 1'b0, 2'b01));
        vecs.push_back(mk(2'b11, P_X,  P_L,  1'b1, 1'b0, 2'b10));
        vecs.push_back(mk(2'b00, P_X,  P_X,  1'b1, 1'b0, 2'b00));
        // backpressure
        vecs.push_back(mk(2'b01, P_IO, P_X, 1'b0, 1'b0, 2'b01));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(2'b10, P_C, P_L, 1'b0, 1'b0, 2'b00));
        vecs.push_back(mk(2'b10, P_C, P_L, 1'b1, 1'b0, 2'b10));
        vecs.push_back(mk(2'b00, P_X, P_X, 1'b1, 1'b0, 2'b00));
        // flush beats yumi and blocks the grant
        vecs.push_back(mk(2'b01, P_L, P_X, 1'b0, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, P_L, P_X, 1'b1, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, P_X, P_X, 1'b0, 1'b0, 2'b00));
        // fill with requester 0 so the preference points at 1
        vecs.push_back(mk(2'b01, P_IO, P_C, 1'b0, 1'b0, 2'b01));
        run_vecs();

        // asynchronous reset while full
        @(posedge clk_i);
        #2;
        req_v_i = 2'b00;
        reset_n_i = 1'b0;
        #1;
        chk("arst_resp_v", 32'(resp_v_o), 32'd0);
        chk("arst_resp_id", 32'(resp_id_o), 32'd0);
        chk("arst_resp_ptag", 32'(resp_ptag_o), 32'd0);
        chk("arst_resp_unc", 32'(resp_uncached_o), 32'd0);
        sb.delete();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        vecs.push_back(mk(2'b11, P_IO, P_C, 1'b0, 1'b0, 2'b01));
        vecs.push_back(mk(2'b00, P_X,  P_X, 1'b1, 1'b0, 2'b00));
        run_vecs();

`ifdef BP_PMA_SCHED_STATS_EN
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #2;
        chk("st_rst", 32'(uc_count_o), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        vecs.push_back(mk(2'b01, P_L,  P_X, 1'b0, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, P_IO, P_X, 1'b1, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, P_C,  P_X, 1'b1, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, P_L,  P_X, 1'b1, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, P_C,  P_X, 1'b1, 1'b0, 2'b01));
        vecs.push_back(mk(2'b00, P_X,  P_X, 1'b1, 1'b0, 2'b00));
        run_vecs();
        @(negedge clk_i);
        #1;
        chk("st_count3", 32'(uc_count_o), 32'd3);
        vecs.push_back(mk(2'b01, P_L, P_X, 1'b0, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, P_L, P_X, 1'b1, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, P_X, P_X, 1'b0, 1'b0, 2'b00));
        run_vecs();
        chk("st_flush", 32'(uc_count_o), 32'd3);
        req_v_i = 2'b01;
        req_ptag_i = {P_X, P_L};
        resp_yumi_i = 1'b0;
        @(posedge clk_i);
        #1;
        resp_yumi_i = 1'b1;
        repeat (65532) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("st_full", 32'(uc_count_o), 32'hFFFF);
        @(negedge clk_i);
        #1;
        chk("st_sat", 32'(uc_count_o), 32'hFFFF);
        req_v_i = 2'b00;
        @(negedge clk_i);
        resp_yumi_i = 1'b0;
`endif

        @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
